regfile: RTL and testbench
==========================

# regfile

General-purpose register file for the 5-stage MIPS pipeline: 32 x 32-bit registers with one synchronous write port and two combinational read ports. The write port is driven by the MEM/WB pipeline register, which latches the MEM stage's `wd_o`/`wreg_o`/`wdata_o`. The two read ports serve the ID stage's operand fetch. A same-cycle write-to-read bypass lets ID see a value that is being written back in the same cycle.

## Interface
Parameters: none. Widths come from the shared defines: `RegBus` = 32, `RegAddrBus` = 5, `RegNum` = 32.
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high (`RstEnable` = 1)
- we  in  1  write enable from MEM/WB (`wreg`)
- waddr  in  `RegAddrBus`  destination register from MEM/WB (`wd`)
- wdata  in  `RegBus`  writeback data from MEM/WB
- re1  in  1  read enable, port 1 (ID operand rs)
- raddr1  in  `RegAddrBus`  read address, port 1
- rdata1  out  `RegBus`  read data, port 1, combinational
- re2  in  1  read enable, port 2 (ID operand rt)
- raddr2  in  `RegAddrBus`  read address, port 2
- rdata2  out  `RegBus`  read data, port 2, combinational

## Operation
- Storage: array `regs[0:31]`, 32 bits each. `regs[0]` is never written, so $zero always reads as 0.
- Reset: when a rising edge samples rst=1, all 32 entries are cleared to `ZeroWord`. The write port is ignored on that edge.
- Write: on a rising edge with rst=0, we=1 and waddr != 0, set `regs[waddr] <= wdata`.
  - A write with waddr=0 is dropped silently.
  - we=0 leaves the array unchanged.
- Read, each port independently, in priority order:
  1. rst=1 -> `ZeroWord`
  2. raddr = 0 -> `ZeroWord`
  3. re=1, we=1 and raddr = waddr -> wdata (bypass)
  4. re=1 -> `regs[raddr]`
  5. re=0 -> `ZeroWord`
- Both ports may address the same register, and may both hit the bypass in the same cycle. Each port returns the identical value.
- No X may propagate from an unread port; a disabled port drives `ZeroWord`.

## Timing
- Write latency:
  - The new value appears on a matching read port in the same cycle, via the bypass.
  - It is available from the array on the cycle after the edge.
- Read latency: 0 cycles. Reads are purely combinational from raddr, re, we, waddr, wdata, rst and the array.
- Reset mid-operation:
  - Read outputs go to 0 in the same cycle rst rises.
  - Array contents clear on the next rising edge.
  - A write pending on that edge is lost.
  - After rst falls, normal writes resume on the first edge with rst=0.
- Reset values: rdata1 = rdata2 = `ZeroWord`; every `regs[i]` = 0 after one reset edge.
- Together with the EX->ID and MEM->ID forwarding paths, the bypass resolves RAW hazards at distance 3 without a stall.

## Structure
- The shared defines header supplies: `RegBus`, `RegAddrBus`, `RegNum`, `RegNumLog2`, `ZeroWord`, `NOPRegAddr`, `RstEnable`, `WriteEnable`, `ReadEnable`. No new constants are introduced.
- Single module, no sub-modules. The two read ports are identical always-blocks; the write port is one clocked always-block.
- Instantiated in the top-level CPU. The write port connects to the mem_wb register outputs; the read ports connect to id.

## Test plan
- Reset clear: preload r5 = 0x12345678, then hold rst=1 for 1 edge with re1=1, raddr1=5 -> rdata1=0 during reset and after rst falls.
- Write then read: write r7 = 0xDEADBEEF on edge N, then read port 2 at raddr2=7 in cycle N+1 -> rdata2=0xDEADBEEF.
- Bypass: in one cycle drive we=1, waddr=9, wdata=0xCAFEF00D with re1=1, raddr1=9 and re2=1, raddr2=9 -> both ports return 0xCAFEF00D before the edge.
- $zero: write 0xFFFFFFFF to waddr=0, then read raddr1=0 both with the bypass active and on the next cycle -> 0 both times.
- Read disable: r3 = 0x55AA55AA, re2=0, raddr2=3 -> rdata2=0; raise re2=1 -> rdata2=0x55AA55AA.
- Reset mid-write: assert rst on the same edge as a write of r4 = 0x11111111 -> r4 reads 0 after rst falls. The next write, r4 = 0x22222222, reads back correctly.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and constants for the MIPS pipeline register file.
// Every value here mirrors the pipeline's shared defines.
package regfile_pkg;
  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;

  localparam logic [RegBus-1:0]     ZeroWord    = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr  = '0;
  localparam logic                  RstEnable   = 1'b1;
  localparam logic                  WriteEnable = 1'b1;
  localparam logic                  ReadEnable  = 1'b1;

  typedef logic [RegBus-1:0]     reg_word_t;
  typedef logic [RegNumLog2-1:0] reg_addr_t;
endpackage

// File: rtl/regfile.sv
// 32 x 32-bit GPR file: one synchronous write port (MEM/WB), two combinational
// read ports (ID) with same-cycle write-to-read bypass. $zero always reads 0.
module regfile
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [RegAddrBus-1:0] waddr,
  input  logic [RegBus-1:0]     wdata,
  input  logic                  re1,
  input  logic [RegAddrBus-1:0] raddr1,
  output logic [RegBus-1:0]     rdata1,
  input  logic                  re2,
  input  logic [RegAddrBus-1:0] raddr2,
  output logic [RegBus-1:0]     rdata2
);

  reg_word_t regs [0:RegNum-1];

  // Reset takes priority over the write port; entry 0 is never written.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < RegNum; i++) begin
        regs[i] <= ZeroWord;
      end
    end else if ((we == WriteEnable) && (waddr != NOPRegAddr)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = ZeroWord;
    if (rst == RstEnable) begin
      rdata1 = ZeroWord;
    end else if (raddr1 == NOPRegAddr) begin
      rdata1 = ZeroWord;
    end else if ((re1 == ReadEnable) && (we == WriteEnable) && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end else if (re1 == ReadEnable) begin
      rdata1 = regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = ZeroWord;
    if (rst == RstEnable) begin
      rdata2 = ZeroWord;
    end else if (raddr2 == NOPRegAddr) begin
      rdata2 = ZeroWord;
    end else if ((re2 == ReadEnable) && (we == WriteEnable) && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end else if (re2 == ReadEnable) begin
      rdata2 = regs[raddr2];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: a vector table walked one clock per entry,
// followed by a fill-all/read-all sequence checked against a scoreboard.
module tb_regfile;
  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, compare 1 ns later, let the rising edge commit.
  task automatic drive(input vec_t v);
    @(negedge clk);
    rst    = v.rst;
    we     = v.we;
    waddr  = v.waddr;
    wdata  = v.wdata;
    re1    = v.re1;
    raddr1 = v.raddr1;
    re2    = v.re2;
    raddr2 = v.raddr2;
    #1;
  endtask

  logic [31:0] model [32];

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;

    //          rst   we    waddr  wdata          re1   ra1    re2   ra2    exp1           exp2
    vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         32'h0};
    vecs[1]  = '{1'b0, 1'b1, 5'd5,  32'h12345678,  1'b1, 5'd5,  1'b0, 5'd5,  32'h12345678,  32'h0};
    vecs[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  1'b0, 5'd0,  32'h0,         32'h0};
    vecs[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  1'b1, 5'd5,  32'h0,         32'h0};
    vecs[4]  = '{1'b0, 1'b1, 5'd7,  32'hDEADBEEF,  1'b1, 5'd5,  1'b1, 5'd7,  32'h0,         32'hDEADBEEF};
    vecs[5]  = '{1'b0, 1'b0, 5'd7,  32'h0,         1'b0, 5'd7,  1'b1, 5'd7,  32'h0,         32'hDEADBEEF};
    vecs[6]  = '{1'b0, 1'b1, 5'd9,  32'hCAFEF00D,  1'b1, 5'd9,  1'b1, 5'd9,  32'hCAFEF00D,  32'hCAFEF00D};
    vecs[7]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF,  1'b1, 5'd0,  1'b1, 5'd9,  32'h0,         32'hCAFEF00D};
    vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  1'b1, 5'd0,  32'h0,         32'h0};
    vecs[9]  = '{1'b0, 1'b1, 5'd3,  32'h55AA55AA,  1'b1, 5'd3,  1'b0, 5'd3,  32'h55AA55AA,  32'h0};
    vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  1'b0, 5'd3,  32'h55AA55AA,  32'h0};
    vecs[11] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd9,  1'b1, 5'd3,  32'h0,         32'h55AA55AA};
    vecs[12] = '{1'b1, 1'b1, 5'd4,  32'h11111111,  1'b1, 5'd4,  1'b1, 5'd3,  32'h0,         32'h0};
    vecs[13] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd4,  1'b1, 5'd3,  32'h0,         32'h0};
    vecs[14] = '{1'b0, 1'b1, 5'd4,  32'h22222222,  1'b1, 5'd4,  1'b1, 5'd4,  32'h22222222,  32'h22222222};
    vecs[15] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd4,  1'b1, 5'd9,  32'h22222222,  32'h0};
    vecs[16] = '{1'b0, 1'b1, 5'd10, 32'hABCD0123,  1'b0, 5'd10, 1'b1, 5'd10, 32'h0,         32'hABCD0123};
    vecs[17] = '{1'b0, 1'b1, 5'd11, 32'h00000001,  1'b1, 5'd10, 1'b1, 5'd11, 32'hABCD0123,  32'h00000001};

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      check($sformatf("vec%0d rdata1", i), rdata1, vecs[i].exp1);
      check($sformatf("vec%0d rdata2", i), rdata2, vecs[i].exp2);
    end

    // Reset, then fill r1..r31 and read back every entry from the array.
    drive('{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0});
    model[0] = 32'h0;
    for (int r = 1; r < 32; r++) begin
      model[r] = $urandom_range(32'hFFFF, 1) ^ (r << 20);
      drive('{1'b0, 1'b1, r[4:0], model[r], 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0});
    end
    for (int r = 0; r < 32; r++) begin
      exp_q.push_back(model[r]);
      exp_q.push_back(model[31 - r]);
    end
    for (int r = 0; r < 32; r++) begin
      logic [31:0] e1;
      logic [31:0] e2;
      logic [4:0]  a2;
      a2 = 5'(31 - r);
      drive('{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, r[4:0], 1'b1, a2, 32'h0, 32'h0});
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      check($sformatf("fill r%0d port1", r), rdata1, e1);
      check($sformatf("fill r%0d port2", 31 - r), rdata2, e2);
    end

    // Write to r12 while both ports read r12: bypass first, array next cycle.
    drive('{1'b0, 1'b1, 5'd12, 32'h0F0F0F0F, 1'b1, 5'd12, 1'b1, 5'd12, 32'h0, 32'h0});
    check("bypass r12 port1", rdata1, 32'h0F0F0F0F);
    check("bypass r12 port2", rdata2, 32'h0F0F0F0F);
    drive('{1'b0, 1'b0, 5'd12, 32'h0, 1'b1, 5'd12, 1'b1, 5'd13, 32'h0, 32'h0});
    check("array r12 port1", rdata1, 32'h0F0F0F0F);
    check("array r13 port2", rdata2, model[13]);

    // rst high mid-operation zeroes outputs before any edge.
    drive('{1'b1, 1'b1, 5'd12, 32'h77777777, 1'b1, 5'd12, 1'b1, 5'd13, 32'h0, 32'h0});
    check("rst mid port1", rdata1, 32'h0);
    check("rst mid port2", rdata2, 32'h0);
    drive('{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b1, 5'd13, 32'h0, 32'h0});
    check("post rst r12", rdata1, 32'h0);
    check("post rst r13", rdata2, 32'h0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
